// File: rtl/burst_memory.sv
// Byte-addressed memory with big-endian 32-bit words and 1/4/8/16-word read/write bursts.
// Beat 0 is performed on the accept edge; later beats follow on consecutive edges.
module burst_memory #(
    parameter int unsigned MEM_BYTES = 1048576,
    parameter logic [31:0] BASE_ADDR = 32'h80020000,
    parameter int unsigned MAX_BURST = 16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] address,
    input  logic [31:0] data_in,
    input  logic [1:0]  access_size,
    input  logic        rw,
    input  logic        enable,
    input  logic        do_branch,
    input  logic [31:0] wm_bypass,
    input  logic        do_wm_bypass,
    output logic        busy,
    output logic [31:0] data_out,
    output logic        data_valid,
    output logic        addr_err
);

    localparam int unsigned AW       = $clog2(MEM_BYTES);
    localparam logic [31:0] LAST_OFF = MEM_BYTES - 32'd4;
    localparam logic [4:0]  MAX_LEN  = 5'(MAX_BURST);

    typedef enum logic [1:0] {StIdle, StRdBurst, StWrBurst} state_e;

    logic [7:0]  r_mem [MEM_BYTES];

    state_e      r_state, w_state_d;
    logic [4:0]  r_beat, w_beat_d;
    logic [4:0]  r_len, w_len_d;
    logic [31:0] r_addr, w_addr_d;
    logic [31:0] r_data_out, w_data_out_d;
    logic        r_data_valid, w_data_valid_d;
    logic        r_addr_err, w_addr_err_d;

    logic [4:0]    w_len;
    logic          w_go;
    logic          w_is_read;
    logic [31:0]   w_beat_addr;
    logic [31:0]   w_offset;
    logic          w_in_range;
    logic [AW-1:0] w_idx;
    logic          w_abort;
    logic [31:0]   w_wdata;
    logic [31:0]   w_rdata;
    logic          w_mem_we;

    // Decode the beat performed at this edge, whether accepting or mid-burst.
    always_comb begin
        unique case (access_size)
            2'b00:   w_len = 5'd1;
            2'b01:   w_len = 5'd4;
            2'b10:   w_len = 5'd8;
            default: w_len = 5'd16;
        endcase
        if (w_len > MAX_LEN) begin
            w_len = MAX_LEN;
        end

        w_go        = 1'b1;
        w_is_read   = (r_state == StRdBurst);
        w_beat_addr = r_addr + {25'd0, r_beat, 2'b00};
        if (r_state == StIdle) begin
            w_go        = enable;
            w_is_read   = rw;
            w_beat_addr = address & ~32'd3;
        end
    end

    // Unsigned offset: addresses below the base wrap high and fail the same bound.
    assign w_offset   = w_beat_addr - BASE_ADDR;
    assign w_in_range = (w_offset <= LAST_OFF);
    assign w_idx      = w_offset[AW-1:0];
    assign w_abort    = w_go & w_is_read & do_branch;
    assign w_wdata    = do_wm_bypass ? wm_bypass : data_in;
    assign w_mem_we   = w_go & ~w_is_read & w_in_range & ~reset;
    assign w_rdata    = {r_mem[w_idx], r_mem[w_idx | AW'(1)],
                         r_mem[w_idx | AW'(2)], r_mem[w_idx | AW'(3)]};

    always_comb begin
        w_state_d = r_state;
        w_beat_d  = r_beat;
        w_len_d   = r_len;
        w_addr_d  = r_addr;
        unique case (r_state)
            StIdle: begin
                if (enable && !w_abort && (w_len > 5'd1)) begin
                    w_state_d = rw ? StRdBurst : StWrBurst;
                    w_beat_d  = 5'd1;
                    w_len_d   = w_len;
                    w_addr_d  = w_beat_addr;
                end
            end
            StRdBurst, StWrBurst: begin
                if (w_abort || (r_beat == r_len - 5'd1)) begin
                    w_state_d = StIdle;
                    w_beat_d  = 5'd0;
                end else begin
                    w_beat_d = r_beat + 5'd1;
                end
            end
            default: begin
                w_state_d = StIdle;
                w_beat_d  = 5'd0;
            end
        endcase
    end

    always_comb begin
        w_data_out_d   = r_data_out;
        w_data_valid_d = 1'b0;
        w_addr_err_d   = 1'b0;
        if (w_go) begin
            if (w_abort) begin
                w_data_out_d = 32'd0;
            end else begin
                w_addr_err_d = ~w_in_range;
                if (w_is_read) begin
                    w_data_valid_d = 1'b1;
                    w_data_out_d   = w_in_range ? w_rdata : 32'd0;
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state      <= StIdle;
            r_beat       <= 5'd0;
            r_len        <= 5'd0;
            r_addr       <= 32'd0;
            r_data_out   <= 32'd0;
            r_data_valid <= 1'b0;
            r_addr_err   <= 1'b0;
        end else begin
            r_state      <= w_state_d;
            r_beat       <= w_beat_d;
            r_len        <= w_len_d;
            r_addr       <= w_addr_d;
            r_data_out   <= w_data_out_d;
            r_data_valid <= w_data_valid_d;
            r_addr_err   <= w_addr_err_d;
        end
    end

    // Storage is never cleared by reset.
    always_ff @(posedge clock) begin
        if (w_mem_we) begin
            r_mem[w_idx]           <= w_wdata[31:24];
            r_mem[w_idx | AW'(1)]  <= w_wdata[23:16];
            r_mem[w_idx | AW'(2)]  <= w_wdata[15:8];
            r_mem[w_idx | AW'(3)]  <= w_wdata[7:0];
        end
    end

    assign busy       = (r_state != StIdle);
    assign data_out   = r_data_out;
    assign data_valid = r_data_valid;
    assign addr_err   = r_addr_err;

endmodule
